// File: rtl/dsp_mac_pkg.sv
// Shared state type and opmode encodings for the DSP MAC sequencer.
package dsp_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Opmode field positions on the DSP48A1-style slice
  localparam int unsigned OPM_X_LO    = 0;
  localparam int unsigned OPM_X_HI    = 1;
  localparam int unsigned OPM_Z_LO    = 2;
  localparam int unsigned OPM_Z_HI    = 3;
  localparam int unsigned OPM_PREADD  = 4;
  localparam int unsigned OPM_CARRYIN = 5;
  localparam int unsigned OPM_PRESUB  = 6;
  localparam int unsigned OPM_POSTSUB = 7;

  localparam logic [1:0] OPM_X_ZERO = 2'd0;
  localparam logic [1:0] OPM_X_M    = 2'd1;
  localparam logic [1:0] OPM_Z_ZERO = 2'd0;
  localparam logic [1:0] OPM_Z_P    = 2'd2;

  localparam logic [7:0] OP_CLR_ACC = 8'h01;
  localparam logic [7:0] OP_ACC     = 8'h09;
  localparam logic [7:0] OP_HOLD    = 8'h08;

endpackage

// File: rtl/dsp_ctrl_delay.sv
// Fixed-depth control delay line with synchronous reset to a fill value.
module dsp_ctrl_delay
  import dsp_mac_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter int unsigned      DEPTH = 2,
  parameter logic [WIDTH-1:0] FILL  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= FILL;
    end else begin
      stage[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Multiply-accumulate job sequencer driving one DSP48A1-style slice.
// Optional sticky overflow flag enabled by defining DSP_MAC_OVF_EN.
module dsp_mac_sequencer
  import dsp_mac_pkg::*;
#(
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned MULT_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [17:0]      s_a,
  input  logic [17:0]      s_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic             res_ovf,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  input  logic [47:0]      dsp_p,
  input  logic             dsp_carryout
);

  localparam int unsigned        DRAIN_W    = $clog2(MULT_LAT + 3);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(MULT_LAT + 2);

  state_t             state, state_nx;
  logic [LEN_W-1:0]   remaining, remaining_nx;
  logic [DRAIN_W-1:0] drain_cnt, drain_nx;
  logic               first, first_nx;
  logic               cmd_fire, s_fire, capture, acc_push;
  logic [7:0]         op_push, op_line;

  assign cmd_ready = (state == ST_IDLE) && !reset;
  assign s_ready   = (state == ST_RUN) && !reset;
  assign res_valid = (state == ST_DONE);
  assign dsp_ce    = 1'b1;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign s_fire    = s_valid && s_ready;

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    drain_nx     = drain_cnt;
    first_nx     = first;
    op_push      = OP_HOLD;
    acc_push     = 1'b0;
    capture      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (cmd_len == '0) begin
            state_nx = ST_DONE;
          end else begin
            remaining_nx = cmd_len;
            first_nx     = 1'b1;
            state_nx     = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (s_fire) begin
          op_push      = first ? OP_CLR_ACC : OP_ACC;
          acc_push     = !first;
          first_nx     = 1'b0;
          remaining_nx = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state_nx = ST_DRAIN;
            drain_nx = DRAIN_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        // Counter reaches 1 on the cycle the last beat's P is at the slice output
        if (drain_cnt == DRAIN_W'(1)) begin
          capture  = 1'b1;
          drain_nx = '0;
          state_nx = ST_DONE;
        end else begin
          drain_nx = drain_cnt - DRAIN_W'(1);
        end
      end
      ST_DONE: begin
        if (res_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Delay line plus the dsp_opmode register gives MULT_LAT cycles from accept
  dsp_ctrl_delay #(
    .WIDTH (8),
    .DEPTH (MULT_LAT - 1),
    .FILL  (OP_HOLD)
  ) u_op_dly (
    .clk   (clk),
    .reset (reset),
    .din   (op_push),
    .dout  (op_line)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      drain_cnt  <= '0;
      first      <= 1'b0;
      dsp_a      <= '0;
      dsp_b      <= '0;
      dsp_opmode <= OP_HOLD;
      res_data   <= '0;
    end else begin
      state      <= state_nx;
      remaining  <= remaining_nx;
      drain_cnt  <= drain_nx;
      first      <= first_nx;
      dsp_opmode <= op_line;
      if (s_fire) begin
        dsp_a <= s_a;
        dsp_b <= s_b;
      end
      if (cmd_fire) res_data <= '0;
      else if (capture) res_data <= dsp_p;
    end
  end

`ifdef DSP_MAC_OVF_EN
  logic acc_q, ovf_sticky, ovf_now;

  // Qualifier lands on the cycle the matching P/carryout is visible
  dsp_ctrl_delay #(
    .WIDTH (1),
    .DEPTH (MULT_LAT + 2),
    .FILL  (1'b0)
  ) u_ovf_dly (
    .clk   (clk),
    .reset (reset),
    .din   (acc_push),
    .dout  (acc_q)
  );

  assign ovf_now = ovf_sticky || (acc_q && dsp_carryout);

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
      res_ovf    <= 1'b0;
    end else if (cmd_fire) begin
      ovf_sticky <= 1'b0;
      res_ovf    <= 1'b0;
    end else begin
      ovf_sticky <= ovf_now;
      if (capture) res_ovf <= ovf_now;
    end
  end
`else
  logic unused_ovf_inputs;
  assign unused_ovf_inputs = dsp_carryout | acc_push;
  assign res_ovf           = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench: DUT plus a behavioural slice, checked against a job-level model.
module tb_dsp_mac_sequencer;
  import dsp_mac_pkg::*;

  localparam int unsigned LEN_W    = 16;
  localparam int unsigned MULT_LAT = 3;

  logic             clk = 1'b0;
  logic             reset, cmd_valid, cmd_ready, s_valid, s_ready;
  logic             res_valid, res_ready, res_ovf, dsp_ce, dsp_carryout;
  logic [LEN_W-1:0] cmd_len;
  logic [17:0]      s_a, s_b, dsp_a, dsp_b;
  logic [47:0]      res_data, dsp_p;
  logic [7:0]       dsp_opmode;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.LEN_W(LEN_W), .MULT_LAT(MULT_LAT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
    .dsp_p(dsp_p), .dsp_carryout(dsp_carryout)
  );

  // Behavioural slice: MULT_LAT product stages, OPMODEREG, PREG, CARRYOUTREG
  logic [35:0] m_pipe [MULT_LAT] = '{default: '0};
  logic [7:0]  op_q = OP_HOLD;
  logic [47:0] p_q  = '0;
  logic        co_q = 1'b0;
  logic [47:0] x_mux, z_mux;
  logic [48:0] post_sum;

  always_comb begin
    x_mux = '0;
    z_mux = '0;
    if (op_q[OPM_X_HI:OPM_X_LO] == OPM_X_M) x_mux = {12'd0, m_pipe[MULT_LAT-1]};
    if (op_q[OPM_Z_HI:OPM_Z_LO] == OPM_Z_P) z_mux = p_q;
    post_sum = {1'b0, z_mux} + {1'b0, x_mux};
  end

  always @(posedge clk) begin
    if (dsp_ce) begin
      m_pipe[0] <= 36'(dsp_a) * 36'(dsp_b);
      for (int i = 1; i < MULT_LAT; i++) m_pipe[i] <= m_pipe[i-1];
      op_q <= dsp_opmode;
      p_q  <= post_sum[47:0];
      co_q <= post_sum[48];
    end
  end

  assign dsp_p        = p_q;
  assign dsp_carryout = co_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string what);
    checks++;
    errors++;
    $display("FAIL %s: handshake not seen within bound (cycle %0d)", what, cyc);
  endtask

  // Job-level model: one job in flight, sum of products mod 2^48, result cycle from timing rules
  logic        pending = 1'b0, m_valid = 1'b0, after_rst = 1'b0, first_b = 1'b0;
  logic        m_ovf = 1'b0, cur_rst;
  int unsigned left = 0, rise = 0, e_len, e;
  logic [47:0] m_sum = '0;
  logic [48:0] tmp;
  logic [17:0] m_a = '0, m_b = '0, e_a, e_b;
  logic        e_rst, e_cv, e_sv, e_rr;

  initial begin
    forever begin
      @(posedge clk);
      e_rst = reset; e_cv = cmd_valid; e_len = int'(cmd_len);
      e_sv = s_valid; e_a = s_a; e_b = s_b; e_rr = res_ready;
      cyc++;
      e = cyc - 1;
      #1;
      cur_rst   = reset;
      after_rst = e_rst;
      if (e_rst) begin
        pending = 1'b0; left = 0; m_a = '0; m_b = '0;
      end else if (pending && m_valid && e_rr) begin
        pending = 1'b0;
      end else if (!pending && e_cv) begin
        pending = 1'b1; left = e_len; m_sum = '0; m_ovf = 1'b0; first_b = 1'b1;
        rise = (e_len == 0) ? e + 1 : 32'hFFFF_FFFF;
      end else if (pending && left > 0 && e_sv) begin
        tmp = {1'b0, (first_b ? 48'd0 : m_sum)} + 49'(36'(e_a) * 36'(e_b));
`ifdef DSP_MAC_OVF_EN
        if (tmp[48]) m_ovf = 1'b1;
`endif
        m_sum = tmp[47:0]; first_b = 1'b0; left--; m_a = e_a; m_b = e_b;
        if (left == 0) rise = e + MULT_LAT + 3;
      end
      m_valid = pending && left == 0 && cyc >= rise;

      chk("dsp_ce", 64'(dsp_ce), 64'd1);
      if (cur_rst) begin
        chk("cmd_ready_in_reset", 64'(cmd_ready), 64'd0);
      end else begin
        chk("cmd_ready", 64'(cmd_ready), 64'(!pending));
        chk("s_ready", 64'(s_ready), 64'(pending && left > 0));
        chk("res_valid", 64'(res_valid), 64'(m_valid));
        chk("dsp_a", 64'(dsp_a), 64'(m_a));
        chk("dsp_b", 64'(dsp_b), 64'(m_b));
        if (m_valid) begin
          chk("res_data", 64'(res_data), 64'(m_sum));
          chk("res_ovf", 64'(res_ovf), 64'(m_ovf));
        end
      end
      if (after_rst) begin
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_res_ovf", 64'(res_ovf), 64'd0);
        chk("rst_opmode", 64'(dsp_opmode), 64'h08);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
      end
    end
  end

  logic [17:0] ja [8], jb [8];
  logic [17:0] ca, cb;
  logic        use_const;
  int unsigned gap_at, gap_len, hold_cyc;

  task automatic do_job(input int unsigned len, input logic [47:0] want,
                        input int unsigned want_lat, input logic want_ovf);
    int unsigned n, c, r;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) begin timeout_fail("cmd_accept"); cmd_valid = 1'b0; return; end
    @(negedge clk);
    c = cyc - 1;
    cmd_valid = 1'b0;
    for (int unsigned i = 0; i < len; i++) begin
      if (i == gap_at && gap_len != 0) begin
        s_valid = 1'b0;
        repeat (gap_len) @(negedge clk);
      end
      s_valid = 1'b1;
      s_a = use_const ? ca : ja[i % 8];
      s_b = use_const ? cb : jb[i % 8];
      n = 0;
      while (!s_ready && n < 100) begin @(negedge clk); n++; end
      if (!s_ready) begin timeout_fail("beat_accept"); s_valid = 1'b0; return; end
      @(negedge clk);
    end
    s_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 200) begin @(negedge clk); n++; end
    if (!res_valid) begin timeout_fail("res_valid"); return; end
    r = cyc;
    if (want_lat != 0) chk("latency", 64'(r - c), 64'(want_lat));
    chk("lit_res_data", 64'(res_data), 64'(want));
    chk("lit_res_ovf", 64'(res_ovf), 64'(want_ovf));
    if (hold_cyc != 0) begin
      repeat (hold_cyc) @(negedge clk);
      chk("hold_res_valid", 64'(res_valid), 64'd1);
      chk("hold_res_data", 64'(res_data), 64'(want));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; s_valid = 1'b0;
    s_a = '0; s_b = '0; res_ready = 1'b0;
    use_const = 1'b0; ca = '0; cb = '0; gap_at = 99; gap_len = 0; hold_cyc = 0;
    for (int i = 0; i < 8; i++) begin ja[i] = '0; jb[i] = '0; end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin ja[i] = 18'(i + 1); jb[i] = 18'(i + 5); end
    do_job(4, 48'd70, 4 + MULT_LAT + 3, 1'b0);

    gap_at = 2; gap_len = 2;
    do_job(4, 48'd70, 4 + MULT_LAT + 3 + 2, 1'b0);
    gap_at = 99; gap_len = 0;

    for (int i = 0; i < 3; i++) begin ja[i] = 18'd10; jb[i] = 18'd10; end
    do_job(3, 48'd300, 3 + MULT_LAT + 3, 1'b0);
    ja[0] = 18'd2; jb[0] = 18'd3;
    do_job(1, 48'd6, 1 + MULT_LAT + 3, 1'b0);

    do_job(0, 48'd0, 1, 1'b0);

    ja[0] = 18'd4; jb[0] = 18'd6; ja[1] = 18'd5; jb[1] = 18'd7;
    hold_cyc = 5;
    do_job(2, 48'd59, 2 + MULT_LAT + 3, 1'b0);
    hold_cyc = 0;

    // Abandon a len=4 job after two beats
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = LEN_W'(4);
    @(negedge clk);
    cmd_valid = 1'b0; s_valid = 1'b1; s_a = 18'd5; s_b = 18'd6;
    @(negedge clk);
    s_a = 18'd7; s_b = 18'd8;
    @(negedge clk);
    s_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_dsp_a", 64'(dsp_a), 64'd0);
    chk("mid_rst_dsp_b", 64'(dsp_b), 64'd0);
    chk("mid_rst_opmode", 64'(dsp_opmode), 64'h08);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
    chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
    reset = 1'b0;
    ja[0] = 18'd3; jb[0] = 18'd3;
    do_job(1, 48'd9, 1 + MULT_LAT + 3, 1'b0);

`ifdef DSP_MAC_OVF_EN
    use_const = 1'b1; ca = 18'h3FFFF; cb = 18'h3FFFF;
    do_job(4100, 48'h3F_7FE0_1004, 0, 1'b1);
    use_const = 1'b0;
`endif

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

Sequencer that runs multiply-accumulate jobs on one DSP48A1-style slice. Takes a job length on a command handshake and streams (A, B) sample pairs from a valid/ready input. Drives the slice's A, B, OPMODE and clock-enable ports, then returns the 48-bit accumulated P on a result handshake. Sits between the stream fabric and the `DSP_proj` slice, with the slice built with A0REG=A1REG=B1REG=MREG=PREG=OPMODEREG=CARRYOUTREG=1.

## Interface
- `LEN_W`, 16: job length counter width.
- `MULT_LAT`, 3: cycles from a/b at the slice pins to the product present at the post-adder input.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` / `cmd_ready` in/out 1: job command handshake.
- `cmd_len` in `LEN_W`: number of samples in the job.
- `s_valid` / `s_ready` in/out 1: sample handshake.
- `s_a`, `s_b` in 18: multiplicand and multiplier (unsigned).
- `res_valid` / `res_ready` out/in 1: result handshake.
- `res_data` out 48: accumulated sum.
- `res_ovf` out 1: overflow flag.
- `dsp_a`, `dsp_b` out 18: to slice A, B.
- `dsp_opmode` out 8: to slice opmode.
- `dsp_ce` out 1: drives CEA/CEB/CEM/CEP/CEOPMODE/CECARRYIN.
- `dsp_p` in 48: from slice P.
- `dsp_carryout` in 1: from slice carryout.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `cmd_ready`=1.
  - Accept with len=0 → DONE with `res_data`=0.
  - Accept with len>0 → load remaining count, set `first` flag, go to RUN.
- RUN: `s_ready`=1.
  - Each accepted beat registers `s_a`/`s_b` onto `dsp_a`/`dsp_b`.
  - Each accepted beat pushes opmode into the delay line:
    - OP_CLR_ACC = 8'h01 (X=M, Z=0) on the first beat.
    - OP_ACC = 8'h09 (X=M, Z=P) on later beats.
  - Cycles with no accepted beat push OP_HOLD = 8'h08 (X=0, Z=P). The accumulator is unchanged.
  - Last beat (count hits 1) → DRAIN with drain counter = MULT_LAT+2.
- DRAIN: pushes OP_HOLD. When the counter expires, capture `dsp_p` into `res_data` → DONE.
- DONE: `res_valid`=1. On `res_ready` → IDLE.
- At most one job is in flight. A new command is not accepted until the result is consumed.
- `dsp_ce`=1 in every state. The slice is never stalled; bubbles are expressed through opmode only.
- Arithmetic is the slice's unsigned 48-bit wrap. The sequencer performs no arithmetic.
- `reset`:
  - Outputs return to reset values next edge: state IDLE, delay line filled with OP_HOLD, counters 0.
  - A job in progress is abandoned with no result.
- Reset values:
  - `cmd_ready`=0 during the reset cycle, 1 after.
  - `s_ready`=0, `res_valid`=0, `res_data`=0, `res_ovf`=0.
  - `dsp_a`=0, `dsp_b`=0, `dsp_opmode`=8'h08, `dsp_ce`=1.

## Timing
- Beat accepted at edge t:
  - `dsp_a`/`dsp_b` valid in cycle t+1.
  - The matching opmode appears on `dsp_opmode` in cycle t+MULT_LAT.
  - The slice registers it; post-adder uses it in cycle t+1+MULT_LAT, aligned with M.
  - P reflects the beat in cycle t+2+MULT_LAT.
- Last beat at edge t: `res_valid` rises in cycle t+MULT_LAT+3.
- Job of N back-to-back beats from command acceptance at edge c: `res_valid` rises in cycle c+N+MULT_LAT+3.
- `cmd_len`=0 at edge c: `res_valid` in cycle c+1.
- `res_valid` and `res_data` hold stable until `res_ready` is sampled high.

## Configuration
- `DSP_MAC_OVF_EN` defined:
  - `res_ovf` is a sticky OR of `dsp_carryout`.
  - Sampled on the cycles where a delayed OP_ACC is applied, aligned with its P update.
  - Cleared on command accept. Captured with `res_data`.
- `DSP_MAC_OVF_EN` undefined: `res_ovf` tied 0, no alignment logic.

## Structure
- `dsp_mac_pkg`:
  - State enum.
  - OP_CLR_ACC, OP_ACC, OP_HOLD constants.
  - Opmode field positions: X[1:0], Z[3:2], pre-add enable [4], carry-in [5], pre-sub [6], post-sub [7].
- Sub-module `dsp_ctrl_delay`:
  - Parameterised width and depth, synchronous reset to a fill value.
  - Used for the opmode line (depth MULT_LAT-1).
  - Used for the overflow-qualify line (`DSP_MAC_OVF_EN` only).

## Test plan
- len=4, a=(1,2,3,4), b=(5,6,7,8), back-to-back beats → `res_data`=70, `res_valid` at cmd cycle+4+MULT_LAT+3.
- Same job with `s_valid` low for 2 cycles between beats 2 and 3 → `res_data`=70, result 2 cycles later.
- Two consecutive jobs:
  - First a=b=10 ×3, then a=2, b=3 ×1.
  - Expect 300, then 6 (no carry-over from the first job).
- len=0 → `res_valid` next cycle, `res_data`=0, no `s_ready`.
- `res_ready` held low 5 cycles → `res_valid`/`res_data` stable, `cmd_ready`=0 throughout.
- `reset` pulsed after beat 2 of a len=4 job:
  - All outputs return to reset values.
  - A fresh len=1 job with a=b=3 returns 9.
  - With `DSP_MAC_OVF_EN`: len=4100, a=b=18'h3FFFF → `res_ovf`=1.
